axil_regfile: RTL

AXI-Lite slave register bank that sits directly downstream of the AXI-Lite interface and consumes master transactions through its slave modport signals.
- Provides NUM_REGS-1 read/write control registers, exported to the fabric as a flat bus with per-register write pulses.
- The top register (index NUM_REGS-1) is read-only and mirrors a hardware status input.
- Supports one outstanding write and one outstanding read, with independent AW/W acceptance.

---
 rtl/axil_regfile.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/axil_regfile.sv
// AXI-Lite slave register bank: NUM_REGS-1 read/write control registers plus one
// read-only status register at the top index. One outstanding write and one outstanding read.
module axil_regfile #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 8,
  parameter int NUM_REGS         = 16
) (
  input  logic                                       AXI_ACLK,
  input  logic                                       AXI_ARESETN,
  input  logic [C_AXI_ADDR_WIDTH-1:0]                AXI_AWADDR,
  input  logic [2:0]                                 AXI_AWPROT,
  input  logic                                       AXI_AWVALID,
  output logic                                       AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]                AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]              AXI_WSTRB,
  input  logic                                       AXI_WVALID,
  output logic                                       AXI_WREADY,
  output logic [1:0]                                 AXI_BRESP,
  output logic                                       AXI_BVALID,
  input  logic                                       AXI_BREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]                AXI_ARADDR,
  input  logic [2:0]                                 AXI_ARPROT,
  input  logic                                       AXI_ARVALID,
  output logic                                       AXI_ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]                AXI_RDATA,
  output logic [1:0]                                 AXI_RRESP,
  output logic                                       AXI_RVALID,
  input  logic                                       AXI_RREADY,
  output logic [(NUM_REGS-1)*C_AXI_DATA_WIDTH-1:0]   reg_out,
  output logic [NUM_REGS-2:0]                        wr_pulse,
  input  logic [C_AXI_DATA_WIDTH-1:0]                status_in
);

  localparam int IDX_W  = C_AXI_ADDR_WIDTH - 2;
  localparam int NRW    = NUM_REGS - 1;
  localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
  // One extra bit so that NUM_REGS == 2^IDX_W still compares correctly.
  localparam logic [IDX_W:0] RO_IDX = (IDX_W + 1)'(NUM_REGS - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write-channel state
  logic                        aw_held_q;
  logic [IDX_W-1:0]            awidx_q;
  logic                        w_held_q;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]           wstrb_q;
  logic                        bvalid_q;
  logic [1:0]                  bresp_q;
  logic [NRW-1:0]              wr_pulse_q;
  logic [NRW-1:0]              wr_pulse_d;

  // Read-channel state
  logic                        rvalid_q;
  logic [1:0]                  rresp_q;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                  rresp_d;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_d;

  logic [C_AXI_DATA_WIDTH-1:0] regs_q [NRW];

  logic                        aw_hs;
  logic                        w_hs;
  logic                        ar_hs;
  logic                        commit;
  logic                        w_is_rw;
  logic [IDX_W-1:0]            w_idx;
  logic [C_AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]           w_strb;
  logic [IDX_W-1:0]            r_idx;

  logic                        unused_ok;
  assign unused_ok = ^{AXI_AWPROT, AXI_ARPROT, AXI_AWADDR[1:0], AXI_ARADDR[1:0]};

  // Handshakes and ready generation
  assign AXI_AWREADY = ~aw_held_q & ~bvalid_q & AXI_ARESETN;
  assign AXI_WREADY  = ~w_held_q  & ~bvalid_q & AXI_ARESETN;
  assign AXI_ARREADY = ~rvalid_q  & AXI_ARESETN;

  assign aw_hs = AXI_AWVALID & AXI_AWREADY;
  assign w_hs  = AXI_WVALID  & AXI_WREADY;
  assign ar_hs = AXI_ARVALID & AXI_ARREADY;

  // Each half comes either from its holding register or straight off the bus this cycle.
  assign w_idx   = aw_held_q ? awidx_q : AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2];
  assign w_data  = w_held_q  ? wdata_q : AXI_WDATA;
  assign w_strb  = w_held_q  ? wstrb_q : AXI_WSTRB;
  assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign w_is_rw = {1'b0, w_idx} < RO_IDX;

  assign r_idx   = AXI_ARADDR[C_AXI_ADDR_WIDTH-1:2];

  // One-hot select of the committed RW register; doubles as the next write pulse.
  always_comb begin
    wr_pulse_d = '0;
    if (commit && w_is_rw) begin
      for (int k = 0; k < NRW; k++) begin
        if (w_idx == IDX_W'(k)) begin
          wr_pulse_d[k] = 1'b1;
        end
      end
    end
  end

  // Read data mux, sampled on the AR handshake edge.
  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_SLVERR;
    if ({1'b0, r_idx} < RO_IDX) begin
      rresp_d = RESP_OKAY;
      for (int k = 0; k < NRW; k++) begin
        if (r_idx == IDX_W'(k)) begin
          rdata_d = regs_q[k];
        end
      end
    end else if ({1'b0, r_idx} == RO_IDX) begin
      rresp_d = RESP_OKAY;
      rdata_d = status_in;
    end
  end

  // Write address/data holding and response
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      aw_held_q  <= 1'b0;
      awidx_q    <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= wr_pulse_d;
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= w_is_rw ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          awidx_q   <= AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          wdata_q  <= AXI_WDATA;
          wstrb_q  <= AXI_WSTRB;
        end
        if (bvalid_q && AXI_BREADY) begin
          bvalid_q <= 1'b0;
        end
      end
    end
  end

  // Register bank, byte-lane write enables
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      for (int k = 0; k < NRW; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NRW; k++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_pulse_d[k] && w_strb[b]) begin
            regs_q[k][b*8 +: 8] <= w_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read response
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end else if (rvalid_q && AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign AXI_BVALID = bvalid_q;
  assign AXI_BRESP  = bresp_q;
  assign AXI_RVALID = rvalid_q;
  assign AXI_RRESP  = rresp_q;
  assign AXI_RDATA  = rdata_q;
  assign wr_pulse   = wr_pulse_q;

  for (genvar k = 0; k < NRW; k++) begin : g_reg_out
    assign reg_out[k*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH] = regs_q[k];
  end

endmodule
